// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin write-port arbiter for sync_fifo with credit-based occupancy tracking.
// Optional macro SYNC_FIFO_ARB_PRIO0_EN gives requester 0 strict priority.
module sync_fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_wdata,
    input  logic                     fifo_rd_en,
    input  logic                     fifo_wr_error,
    output logic [CNT_WIDTH-1:0]     level,
    output logic                     arb_empty,
    output logic                     arb_full,
    output logic                     err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] win_idx;
    logic [WIDTH-1:0] win_data;
    logic             any_gnt;
    logic             prio_hit;
    logic             can_acc;
    logic             rd_ok;
    int unsigned      cand;

    // The in-flight push counts as occupied; a same-cycle read never frees a slot.
    assign can_acc   = (int'(level) + int'(fifo_wr_en)) < DEPTH;
    assign rd_ok     = fifo_rd_en && (level != '0);
    assign arb_empty = (level == '0);
    assign arb_full  = (int'(level) == DEPTH);

    always_comb begin
        any_gnt  = 1'b0;
        prio_hit = 1'b0;
        win_idx  = '0;
        cand     = 0;
`ifdef SYNC_FIFO_ARB_PRIO0_EN
        if (can_acc && req[0]) begin
            any_gnt  = 1'b1;
            prio_hit = 1'b1;
        end
`endif
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_REQ;
            if (!any_gnt && can_acc && req[PTR_W'(cand)]) begin
                any_gnt = 1'b1;
                win_idx = PTR_W'(cand);
            end
        end
    end

    assign win_data = req_data[win_idx*WIDTH +: WIDTH];

    always_comb begin
        gnt = '0;
        if (any_gnt && !rst)
            gnt[win_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            fifo_wr_en <= 1'b0;
            fifo_wdata <= '0;
        end else begin
            fifo_wr_en <= any_gnt;
            if (any_gnt)
                fifo_wdata <= win_data;
            if (any_gnt && !prio_hit)
                rr_ptr <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
            err   <= 1'b0;
        end else begin
            case ({fifo_wr_en, rd_ok})
                2'b10:   if (int'(level) < DEPTH) level <= level + CNT_WIDTH'(1);
                2'b01:   level <= level - CNT_WIDTH'(1);
                default: level <= level;
            endcase
            if ((fifo_rd_en && level == '0) || fifo_wr_error)
                err <= 1'b1;
        end
    end

endmodule
